// File: rtl/imem_loader.sv
// Program loader: streams words into instruction memory while the CPU is held in
// reset, verifies a trailing 32-bit additive checksum, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int RELEASE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CKSUM   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      REL_LOAD = 4'(RELEASE_CYC);

  logic [2:0]  state;
  logic [31:0] sum;
  logic [3:0]  rel_cnt;
  logic        accept;
  logic        full;

  assign in_ready = (state == S_LOAD) || (state == S_CKSUM);
  assign accept   = in_valid && in_ready;
  assign full     = (word_count == CAPACITY);

  // A word arriving once memory is full has nowhere to go, so it is never
  // written and the session fails instead of wrapping onto address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cpu_hold   <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      sum        <= '0;
      rel_cnt    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          word_count <= '0;
          sum        <= '0;
          error      <= 1'b0;
          done       <= 1'b0;
          cpu_hold   <= 1'b1;
          if (start) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (full) begin
              state    <= S_ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
            end else begin
              wr_en      <= 1'b1;
              wr_addr    <= word_count[ADDR_W-1:0];
              wr_data    <= in_data;
              sum        <= sum + in_data;
              word_count <= word_count + 1'b1;
              if (in_last) begin
                state <= S_CKSUM;
              end
            end
          end
        end
        S_CKSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              state   <= S_RELEASE;
              rel_cnt <= REL_LOAD;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        S_RELEASE: begin
          if (rel_cnt == 4'd0) begin
            state    <= S_RUN;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt - 4'd1;
          end
        end
        S_RUN, S_ERR: begin
          if (start) begin
            state      <= S_LOAD;
            cpu_hold   <= 1'b1;
            error      <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            sum        <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 1024-word instance and a 4-word instance share the
// stimulus; a reference model of the image predicts writes, sum and outcome.
module tb_imem_loader;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;

  logic        b_ready, b_wen, b_hold, b_done, b_err;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [10:0] b_count;

  logic        s_ready, s_wen, s_hold, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  bit          sel = 1'b0;
  logic        ready, wen, hold, dn, err;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic [10:0] count;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          m_count;
  logic [31:0] m_sum;
  wr_t         wlog[$];
  wr_t         expq[$];

  imem_loader #(.ADDR_W(10), .RELEASE_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_ready), .wr_en(b_wen), .wr_addr(b_addr),
    .wr_data(b_wdata), .cpu_hold(b_hold), .done(b_done), .error(b_err),
    .word_count(b_count)
  );

  imem_loader #(.ADDR_W(2), .RELEASE_CYC(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(s_ready), .wr_en(s_wen), .wr_addr(s_addr),
    .wr_data(s_wdata), .cpu_hold(s_hold), .done(s_done), .error(s_err),
    .word_count(s_count)
  );

  assign ready = sel ? s_ready : b_ready;
  assign wen   = sel ? s_wen   : b_wen;
  assign hold  = sel ? s_hold  : b_hold;
  assign dn    = sel ? s_done  : b_done;
  assign err   = sel ? s_err   : b_err;
  assign waddr = sel ? {8'b0, s_addr} : b_addr;
  assign wdata = sel ? s_wdata : b_wdata;
  assign count = sel ? {8'b0, s_count} : b_count;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe seen mid-cycle is logged with the cycle it follows.
  always @(negedge clk) begin
    if (wen === 1'b1) wlog.push_back('{cyc, waddr, wdata});
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int cap();
    return sel ? 4 : 1024;
  endfunction

  function automatic int rc();
    return sel ? 2 : 4;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, output int acc);
    acc      = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 40; n++) begin
      if (ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_output("accept", 64'(acc >= 0), 64'(1));
  endtask

  task automatic send_prog(input logic [31:0] d, input logic last);
    int acc;
    send_word(d, last, acc);
    if (m_count < cap()) begin
      expq.push_back('{acc, 10'(m_count), d});
      m_sum   = m_sum + d;
      m_count = m_count + 1;
    end
  endtask

  task automatic send_cksum(input logic [31:0] c, input bit good);
    int acc;
    send_word(c, 1'($urandom_range(0, 1)), acc);
    if (good) begin
      check_output("release_ready", 64'(ready), 64'(0));
      tick(rc());
      check_output("hold_before_run", 64'(hold), 64'(1));
      check_output("done_before_run", 64'(dn), 64'(0));
      tick(1);
      check_output("hold_in_run", 64'(hold), 64'(0));
      check_output("done_in_run", 64'(dn), 64'(1));
      check_output("error_in_run", 64'(err), 64'(0));
    end else begin
      check_output("error_on_bad", 64'(err), 64'(1));
      check_output("hold_on_bad", 64'(hold), 64'(1));
      check_output("done_on_bad", 64'(dn), 64'(0));
    end
  endtask

  task automatic apply_stimulus_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_output("start_hold", 64'(hold), 64'(1));
    check_output("start_done", 64'(dn), 64'(0));
    check_output("start_error", 64'(err), 64'(0));
    check_output("start_ready", 64'(ready), 64'(1));
    check_output("start_count", 64'(count), 64'(0));
    m_count = 0;
    m_sum   = '0;
    wlog.delete();
    expq.delete();
  endtask

  task automatic compare_writes(input string tag);
    check_output({tag, "_nwrites"}, 64'(wlog.size()), 64'(expq.size()));
    for (int i = 0; i < wlog.size() && i < expq.size(); i++) begin
      check_output({tag, "_addr"}, 64'(wlog[i].addr), 64'(expq[i].addr));
      check_output({tag, "_data"}, 64'(wlog[i].data), 64'(expq[i].data));
      check_output({tag, "_cycle"}, 64'(wlog[i].cyc), 64'(expq[i].cyc));
    end
    wlog.delete();
    expq.delete();
  endtask

  initial begin
    int  len;
    bit  good;

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    m_count  = 0;
    m_sum    = '0;

    #12;
    check_output("rst_hold", 64'(hold), 64'(1));
    check_output("rst_ready", 64'(ready), 64'(0));
    check_output("rst_wr_en", 64'(wen), 64'(0));
    check_output("rst_wr_addr", 64'(waddr), 64'(0));
    check_output("rst_wr_data", 64'(wdata), 64'(0));
    check_output("rst_done", 64'(dn), 64'(0));
    check_output("rst_error", 64'(err), 64'(0));
    check_output("rst_count", 64'(count), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);

    $display("[TB] basic load");
    apply_stimulus_start();
    send_prog(32'h20080005, 1'b0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_output("start_ignored_count", 64'(count), 64'(1));
    send_prog(32'h20090003, 1'b0);
    send_prog(32'h01095020, 1'b1);
    check_output("basic_count", 64'(count), 64'(3));
    send_cksum(32'h411A5028, 1'b1);
    tick(1);
    compare_writes("basic");

    $display("[TB] bad checksum, reload from run");
    apply_stimulus_start();
    send_prog(32'h20080005, 1'b0);
    send_prog(32'h20090003, 1'b0);
    send_prog(32'h01095020, 1'b1);
    send_cksum(32'h411A5029, 1'b0);
    tick(2);
    check_output("err_sticky", 64'(err), 64'(1));
    compare_writes("bad");

    $display("[TB] backpressure");
    apply_stimulus_start();
    send_prog(32'hDEADBEEF, 1'b0);
    tick(2);
    send_prog(32'h12345678, 1'b0);
    tick(1);
    send_prog(32'hF0F0F0F0, 1'b1);
    check_output("bp_count", 64'(count), 64'(m_count));
    send_cksum(m_sum, 1'b1);
    tick(1);
    compare_writes("bp");

    $display("[TB] random images");
    for (int it = 0; it < 5; it++) begin
      apply_stimulus_start();
      len  = int'($urandom_range(1, 12));
      good = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < len; i++) begin
        send_prog(32'($urandom), 1'(i == len - 1));
        tick(int'($urandom_range(0, 2)));
      end
      check_output("rand_count", 64'(count), 64'(m_count));
      if (good) send_cksum(m_sum, 1'b1);
      else send_cksum(m_sum ^ (32'd1 << $urandom_range(0, 31)), 1'b0);
      tick(1);
      compare_writes("rand");
    end

    $display("[TB] reset mid-load");
    apply_stimulus_start();
    send_prog(32'hA5A5A5A5, 1'b0);
    send_prog(32'h5A5A5A5A, 1'b0);
    tick(1);
    rst = 1'b0;
    #2;
    check_output("midrst_hold", 64'(hold), 64'(1));
    check_output("midrst_count", 64'(count), 64'(0));
    check_output("midrst_ready", 64'(ready), 64'(0));
    check_output("midrst_wr_en", 64'(wen), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0BAD0BAD;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_output("idle_ready", 64'(ready), 64'(0));
      check_output("idle_count", 64'(count), 64'(0));
    end
    in_valid = 1'b0;
    tick(1);
    compare_writes("midrst");

    $display("[TB] overflow on 4-word memory");
    sel = 1'b1;
    apply_stimulus_start();
    for (int i = 0; i < 4; i++) send_prog(32'($urandom), 1'b0);
    check_output("ovf_count", 64'(count), 64'(4));
    send_prog(32'($urandom), 1'b0);
    check_output("ovf_error", 64'(err), 64'(1));
    check_output("ovf_hold", 64'(hold), 64'(1));
    check_output("ovf_done", 64'(dn), 64'(0));
    tick(2);
    compare_writes("ovf");

    apply_stimulus_start();
    for (int i = 0; i < 4; i++) send_prog(32'($urandom), 1'(i == 3));
    check_output("full_count", 64'(count), 64'(4));
    send_cksum(m_sum, 1'b1);
    tick(1);
    compare_writes("full");

    apply_stimulus_start();
    send_prog(32'($urandom), 1'b1);
    send_cksum(m_sum, 1'b1);
    tick(1);
    compare_writes("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
